// File: rtl/hazard_tracker.sv
// Load-use hazard detector and pipeline tag tracker for a 5-stage in-order core.
// Produces the stall request, the EX/MEM/WB destination tags and a saturating stall counter.
module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Valid,
  input  logic [2:0]       ID_RegA,
  input  logic [2:0]       ID_RegB,
  input  logic             ID_UsesA,
  input  logic             ID_UsesB,
  input  logic [2:0]       ID_DestReg,
  input  logic             ID_RegWr,
  input  logic             ID_MemRd,
  input  logic             Flush,
  input  logic             Mem_Busy,
  input  logic             CntClr,
  output logic             Stall,
  output logic [2:0]       ID_EX_Reg,
  output logic             ID_EX_RegWr,
  output logic             ID_EX_MemRd,
  output logic [2:0]       EX_MEM_Reg,
  output logic             EX_MEM_RegWr,
  output logic [2:0]       MEM_WB_Reg,
  output logic             MEM_WB_RegWr,
  output logic [CNT_W-1:0] StallCount
);

  logic [2:0]       id_ex_reg_q,  id_ex_reg_d;
  logic             id_ex_wr_q,   id_ex_wr_d;
  logic             id_ex_rd_q,   id_ex_rd_d;
  logic [2:0]       ex_mem_reg_q, ex_mem_reg_d;
  logic             ex_mem_wr_q,  ex_mem_wr_d;
  logic [2:0]       mem_wb_reg_q, mem_wb_reg_d;
  logic             mem_wb_wr_q,  mem_wb_wr_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic             src_match;
  logic             bubble;

  // Register 0 is compared like any other register.
  assign src_match = (ID_UsesA && (id_ex_reg_q == ID_RegA)) ||
                     (ID_UsesB && (id_ex_reg_q == ID_RegB));

  assign Stall = ~Mem_Busy & ~Flush & ID_Valid & id_ex_wr_q & id_ex_rd_q & src_match;

  assign bubble = Stall | Flush;

  always_comb begin
    id_ex_reg_d  = id_ex_reg_q;
    id_ex_wr_d   = id_ex_wr_q;
    id_ex_rd_d   = id_ex_rd_q;
    ex_mem_reg_d = ex_mem_reg_q;
    ex_mem_wr_d  = ex_mem_wr_q;
    mem_wb_reg_d = mem_wb_reg_q;
    mem_wb_wr_d  = mem_wb_wr_q;
    if (!Mem_Busy) begin
      mem_wb_reg_d = ex_mem_reg_q;
      mem_wb_wr_d  = ex_mem_wr_q;
      ex_mem_reg_d = id_ex_reg_q;
      ex_mem_wr_d  = id_ex_wr_q;
      if (bubble) begin
        id_ex_reg_d = 3'd0;
        id_ex_wr_d  = 1'b0;
        id_ex_rd_d  = 1'b0;
      end else begin
        id_ex_reg_d = ID_DestReg;
        id_ex_wr_d  = ID_RegWr & ID_Valid;
        id_ex_rd_d  = ID_MemRd & ID_Valid;
      end
    end
  end

  // Clear beats increment, and still acts while the pipeline is frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (CntClr)
      cnt_d = '0;
    else if (Stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_reg_q  <= 3'd0;
      id_ex_wr_q   <= 1'b0;
      id_ex_rd_q   <= 1'b0;
      ex_mem_reg_q <= 3'd0;
      ex_mem_wr_q  <= 1'b0;
      mem_wb_reg_q <= 3'd0;
      mem_wb_wr_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      id_ex_reg_q  <= id_ex_reg_d;
      id_ex_wr_q   <= id_ex_wr_d;
      id_ex_rd_q   <= id_ex_rd_d;
      ex_mem_reg_q <= ex_mem_reg_d;
      ex_mem_wr_q  <= ex_mem_wr_d;
      mem_wb_reg_q <= mem_wb_reg_d;
      mem_wb_wr_q  <= mem_wb_wr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ID_EX_Reg    = id_ex_reg_q;
  assign ID_EX_RegWr  = id_ex_wr_q;
  assign ID_EX_MemRd  = id_ex_rd_q;
  assign EX_MEM_Reg   = ex_mem_reg_q;
  assign EX_MEM_RegWr = ex_mem_wr_q;
  assign MEM_WB_Reg   = mem_wb_reg_q;
  assign MEM_WB_RegWr = mem_wb_wr_q;
  assign StallCount   = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: the driver queues hand-computed expectations,
// a separate monitor pops and compares them against the sampled outputs.
module tb_hazard_tracker;

  localparam int CW = 4;

  typedef struct packed {
    logic       valid;
    logic [2:0] rega;
    logic       usesa;
    logic [2:0] regb;
    logic       usesb;
    logic [2:0] dest;
    logic       regwr;
    logic       memrd;
    logic       flush;
    logic       busy;
    logic       clr;
  } in_t;

  typedef struct packed {
    logic          stall;
    logic [2:0]    ir;
    logic          iw;
    logic          im;
    logic [2:0]    er;
    logic          ew;
    logic [2:0]    mr;
    logic          mw;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          ID_Valid, ID_UsesA, ID_UsesB, ID_RegWr, ID_MemRd;
  logic [2:0]    ID_RegA, ID_RegB, ID_DestReg;
  logic          Flush, Mem_Busy, CntClr;
  logic          Stall, ID_EX_RegWr, ID_EX_MemRd, EX_MEM_RegWr, MEM_WB_RegWr;
  logic [2:0]    ID_EX_Reg, EX_MEM_Reg, MEM_WB_Reg;
  logic [CW-1:0] StallCount;

  hazard_tracker #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Valid(ID_Valid), .ID_RegA(ID_RegA), .ID_RegB(ID_RegB),
    .ID_UsesA(ID_UsesA), .ID_UsesB(ID_UsesB), .ID_DestReg(ID_DestReg),
    .ID_RegWr(ID_RegWr), .ID_MemRd(ID_MemRd), .Flush(Flush),
    .Mem_Busy(Mem_Busy), .CntClr(CntClr), .Stall(Stall),
    .ID_EX_Reg(ID_EX_Reg), .ID_EX_RegWr(ID_EX_RegWr), .ID_EX_MemRd(ID_EX_MemRd),
    .EX_MEM_Reg(EX_MEM_Reg), .EX_MEM_RegWr(EX_MEM_RegWr),
    .MEM_WB_Reg(MEM_WB_Reg), .MEM_WB_RegWr(MEM_WB_RegWr),
    .StallCount(StallCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t  exp_q[$];
  string name_q[$];
  event  chk_ev;
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    drv_done = 1'b0;

  function automatic in_t mk_in(logic v, logic [2:0] ra, logic ua, logic [2:0] rb, logic ub,
                                logic [2:0] d, logic wr, logic rd, logic fl, logic bz, logic cl);
    in_t r;
    r.valid = v; r.rega = ra; r.usesa = ua; r.regb = rb; r.usesb = ub;
    r.dest = d; r.regwr = wr; r.memrd = rd; r.flush = fl; r.busy = bz; r.clr = cl;
    return r;
  endfunction

  function automatic exp_t mk_ex(logic s, logic [2:0] ir, logic iw, logic im, logic [2:0] er,
                                 logic ew, logic [2:0] mr, logic mw, int c);
    exp_t r;
    r.stall = s; r.ir = ir; r.iw = iw; r.im = im; r.er = er; r.ew = ew;
    r.mr = mr; r.mw = mw; r.cnt = CW'(c);
    return r;
  endfunction

  task automatic apply(input in_t i);
    ID_Valid = i.valid; ID_RegA = i.rega; ID_UsesA = i.usesa; ID_RegB = i.regb;
    ID_UsesB = i.usesb; ID_DestReg = i.dest; ID_RegWr = i.regwr; ID_MemRd = i.memrd;
    Flush = i.flush; Mem_Busy = i.busy; CntClr = i.clr;
  endtask

  task automatic cyc(input string nm, input in_t i, input exp_t e);
    @(posedge clk);
    #1;
    apply(i);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: consumes queued expectations at each falling edge or on demand.
  initial begin
    exp_t  e, a;
    string nm;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {Stall, ID_EX_Reg, ID_EX_RegWr, ID_EX_MemRd, EX_MEM_Reg, EX_MEM_RegWr,
              MEM_WB_Reg, MEM_WB_RegWr, StallCount};
        n_checks++;
        if (a === e) n_pass++;
        else
          $display("FAIL %s: got stall=%0b idex=%0d/%0b/%0b exmem=%0d/%0b memwb=%0d/%0b cnt=%0d, expected stall=%0b idex=%0d/%0b/%0b exmem=%0d/%0b memwb=%0d/%0b cnt=%0d",
                   nm, a.stall, a.ir, a.iw, a.im, a.er, a.ew, a.mr, a.mw, a.cnt,
                   e.stall, e.ir, e.iw, e.im, e.er, e.ew, e.mr, e.mw, e.cnt);
      end
    end
  end

  initial begin
    in_t  idle, ld3, use3, x0;
    exp_t z;
    idle = '0;
    z    = '0;
    apply(idle);
    rst_n = 1'b0;
    #2;
    exp_q.push_back(z); name_q.push_back("in_reset");
    ->chk_ev;
    n_checks++;
    if (Stall === 1'b0) n_pass++;
    else $display("FAIL direct_reset_stall: got %0b, expected 0", Stall);
    n_checks++;
    if (StallCount === '0) n_pass++;
    else $display("FAIL direct_reset_cnt: got %0d, expected 0", StallCount);
    #10 rst_n = 1'b1;

    cyc("after_release", idle, mk_ex(0,0,0,0,0,0,0,0,0));

    // load r3 then dependent read of r3
    ld3  = mk_in(1,0,0,0,0,3,1,1,0,0,0);
    use3 = mk_in(1,3,1,0,0,5,1,0,0,0,0);
    cyc("lu_load",    ld3,  mk_ex(0,0,0,0,0,0,0,0,0));
    cyc("lu_stall",   use3, mk_ex(1,3,1,1,0,0,0,0,0));
    cyc("lu_bubble",  use3, mk_ex(0,0,0,0,3,1,0,0,1));
    cyc("lu_memwb3",  idle, mk_ex(0,5,1,0,0,0,3,1,1));
    cyc("lu_drain1",  idle, mk_ex(0,0,0,0,5,1,0,0,1));
    cyc("lu_drain2",  idle, mk_ex(0,0,0,0,0,0,5,1,1));
    cyc("lu_drain3",  idle, mk_ex(0,0,0,0,0,0,0,0,1));

    // no false stalls
    cyc("nf_load_a",  ld3,                         mk_ex(0,0,0,0,0,0,0,0,1));
    cyc("nf_usesa0",  mk_in(1,3,0,0,0,0,0,0,0,0,0), mk_ex(0,3,1,1,0,0,0,0,1));
    cyc("nf_load_b",  ld3,                         mk_ex(0,0,0,0,3,1,0,0,1));
    cyc("nf_rega4",   mk_in(1,4,1,0,0,0,0,0,0,0,0), mk_ex(0,3,1,1,0,0,3,1,1));
    cyc("nf_alu_r3",  mk_in(1,0,0,0,0,3,1,0,0,0,0), mk_ex(0,0,0,0,3,1,0,0,1));
    cyc("nf_alu_use", mk_in(1,3,1,0,0,0,0,0,0,0,0), mk_ex(0,3,1,0,0,0,3,1,1));
    cyc("nf_drain1",  idle, mk_ex(0,0,0,0,3,1,0,0,1));
    cyc("nf_drain2",  idle, mk_ex(0,0,0,0,0,0,3,1,1));
    cyc("nf_drain3",  idle, mk_ex(0,0,0,0,0,0,0,0,1));

    // flush beats a load-use match on RegB
    cyc("fl_load",    mk_in(1,0,0,0,0,2,1,1,0,0,0), mk_ex(0,0,0,0,0,0,0,0,1));
    cyc("fl_match",   mk_in(1,0,0,2,1,6,1,0,1,0,0), mk_ex(0,2,1,1,0,0,0,0,1));
    cyc("fl_bubble",  idle, mk_ex(0,0,0,0,2,1,0,0,1));
    cyc("fl_drain1",  idle, mk_ex(0,0,0,0,0,0,2,1,1));
    cyc("fl_drain2",  idle, mk_ex(0,0,0,0,0,0,0,0,1));

    // freeze during a load-use match, with a clear while frozen
    cyc("fz_load",    mk_in(1,0,0,0,0,7,1,1,0,0,0), mk_ex(0,0,0,0,0,0,0,0,1));
    cyc("fz_busy1",   mk_in(1,7,1,0,0,1,1,0,0,1,0), mk_ex(0,7,1,1,0,0,0,0,1));
    cyc("fz_busy2",   mk_in(1,7,1,0,0,1,1,0,0,1,0), mk_ex(0,7,1,1,0,0,0,0,1));
    cyc("fz_busy3",   mk_in(1,7,1,0,0,1,1,0,0,1,1), mk_ex(0,7,1,1,0,0,0,0,1));
    cyc("fz_stall",   mk_in(1,7,1,0,0,1,1,0,0,0,0), mk_ex(1,7,1,1,0,0,0,0,0));
    cyc("fz_once",    mk_in(1,7,1,0,0,1,1,0,0,0,0), mk_ex(0,0,0,0,7,1,0,0,1));
    cyc("fz_drain1",  idle, mk_ex(0,1,1,0,0,0,7,1,1));
    cyc("fz_drain2",  idle, mk_ex(0,0,0,0,1,1,0,0,1));
    cyc("fz_drain3",  idle, mk_ex(0,0,0,0,0,0,1,1,1));
    cyc("fz_clr",     mk_in(0,0,0,0,0,0,0,0,0,0,1), mk_ex(0,0,0,0,0,0,0,0,1));

    // r0 load that reads r0: stalls every other cycle
    x0 = mk_in(1,0,0,0,1,0,1,1,0,0,0);
    cyc("sat_first", x0, mk_ex(0,0,0,0,0,0,0,0,0));
    for (int k = 1; k <= 17; k++) begin
      cyc($sformatf("sat_stall_%0d", k), x0,
          mk_ex(1,0,1,1,0,0,0,(k > 1), (k - 1 > 15) ? 15 : k - 1));
      cyc($sformatf("sat_gap_%0d", k), x0,
          mk_ex(0,0,0,0,0,1,0,0, (k > 15) ? 15 : k));
    end
    cyc("clr_vs_stall", mk_in(1,0,0,0,1,0,1,1,0,0,1), mk_ex(1,0,1,1,0,0,0,1,15));
    cyc("clr_result",   idle, mk_ex(0,0,0,0,0,1,0,0,0));

    // async reset mid-stall
    cyc("rs_load",  mk_in(1,0,0,0,0,4,1,1,0,0,0), mk_ex(0,0,0,0,0,0,0,1,0));
    cyc("rs_stall", mk_in(1,4,1,0,0,5,1,0,0,0,0), mk_ex(1,4,1,1,0,0,0,0,0));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(z); name_q.push_back("rs_async_clear");
    ->chk_ev;
    n_checks++;
    if (Stall === 1'b0) n_pass++;
    else $display("FAIL direct_rs_stall: got %0b, expected 0", Stall);
    n_checks++;
    if (ID_EX_RegWr === 1'b0) n_pass++;
    else $display("FAIL direct_rs_idex_wr: got %0b, expected 0", ID_EX_RegWr);
    n_checks++;
    if (EX_MEM_RegWr === 1'b0) n_pass++;
    else $display("FAIL direct_rs_exmem_wr: got %0b, expected 0", EX_MEM_RegWr);
    n_checks++;
    if (MEM_WB_RegWr === 1'b0) n_pass++;
    else $display("FAIL direct_rs_memwb_wr: got %0b, expected 0", MEM_WB_RegWr);
    n_checks++;
    if (StallCount === '0) n_pass++;
    else $display("FAIL direct_rs_cnt: got %0d, expected 0", StallCount);
    @(posedge clk);
    #2 apply(idle);
    #1 rst_n = 1'b1;
    cyc("rs_post1", idle, z);
    cyc("rs_post2", idle, z);
    cyc("rs_post3", idle, z);
    drv_done = 1'b1;
  end

  initial begin
    int guard;
    wait (drv_done);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      $display("FAIL %s: got no sample, expected a monitor comparison", name_q.pop_front());
      n_checks++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion by 50000, expected driver to finish");
    $fatal(1);
  end

endmodule
